// File: rtl/route_distributor_seq_if.sv
// Request/allocation/grant bundle between the lane-request logic and the route distributor.
// master drives requests and releases; slave is the distributor.
interface route_distributor_seq_if #(
    parameter int unsigned CHANNEL_NUM   = 8,
    parameter int unsigned CAPACITOR_NUM = 16
);
    localparam int unsigned CH_W  = $clog2(CHANNEL_NUM);
    localparam int unsigned CAP_W = $clog2(CAPACITOR_NUM);
    localparam int unsigned CNT_W = $clog2(CAPACITOR_NUM + 1);

    logic                     req_valid;
    logic                     req_ready;
    logic [CHANNEL_NUM-1:0]   req_mask;
    logic                     fill_hi;
    logic [CAPACITOR_NUM-1:0] release_mask;
    logic                     alloc_valid;
    logic [CH_W-1:0]          alloc_ch;
    logic [CAP_W-1:0]         alloc_cap;
    logic                     grant_valid;
    logic [CAPACITOR_NUM-1:0] grant_mask;
    logic                     overflow;
    logic [CHANNEL_NUM-1:0]   rem_mask;
    logic [CAPACITOR_NUM-1:0] busy_mask;
    logic [CNT_W-1:0]         free_cnt;

    modport master (
        output req_valid, req_mask, fill_hi, release_mask,
        input  req_ready, alloc_valid, alloc_ch, alloc_cap, grant_valid,
               grant_mask, overflow, rem_mask, busy_mask, free_cnt
    );

    modport slave (
        input  req_valid, req_mask, fill_hi, release_mask,
        output req_ready, alloc_valid, alloc_ch, alloc_cap, grant_valid,
               grant_mask, overflow, rem_mask, busy_mask, free_cnt
    );
endinterface

// File: rtl/route_distributor_seq.sv
// Sequential channel-to-capacitor route allocator: binds one requested channel per cycle
// to a free capacitor slot, tracks occupancy and per-slot releases, reports overflow.
module route_distributor_seq #(
    parameter int unsigned CHANNEL_NUM   = 8,
    parameter int unsigned CAPACITOR_NUM = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    route_distributor_seq_if.slave  bus
);
    localparam int unsigned CH_W  = $clog2(CHANNEL_NUM);
    localparam int unsigned CAP_W = $clog2(CAPACITOR_NUM);
    localparam int unsigned CNT_W = $clog2(CAPACITOR_NUM + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALLOC = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [CHANNEL_NUM-1:0]   pending_q, pending_d;
    logic                     order_q, order_d;
    logic [CAPACITOR_NUM-1:0] busy_q, busy_d;
    logic [CAPACITOR_NUM-1:0] grant_acc_q, grant_acc_d;
    logic [CNT_W-1:0]         free_cnt_q, free_cnt_d;
    logic                     req_ready_q, req_ready_d;
    logic                     alloc_valid_q, alloc_valid_d;
    logic [CH_W-1:0]          alloc_ch_q, alloc_ch_d;
    logic [CAP_W-1:0]         alloc_cap_q, alloc_cap_d;
    logic                     grant_valid_q, grant_valid_d;
    logic [CAPACITOR_NUM-1:0] grant_mask_q, grant_mask_d;
    logic                     overflow_q, overflow_d;
    logic [CHANNEL_NUM-1:0]   rem_mask_q, rem_mask_d;

    logic [CAPACITOR_NUM-1:0] cap_onehot;
    logic [CHANNEL_NUM-1:0]   ch_onehot;
    logic [CH_W-1:0]          nxt_ch;
    logic                     nxt_ch_found;
    logic [CAP_W-1:0]         lo_cap, hi_cap, nxt_cap;
    logic                     nxt_cap_found;

    // The registered alloc outputs hold the decision for the current ALLOC cycle.
    assign cap_onehot = CAPACITOR_NUM'(1) << alloc_cap_q;
    assign ch_onehot  = CHANNEL_NUM'(1) << alloc_ch_q;

    // Next-state and request bookkeeping.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        order_d     = order_q;
        grant_acc_d = grant_acc_q;
        busy_d      = busy_q & ~bus.release_mask;
        overflow_d  = 1'b0;
        rem_mask_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    pending_d   = bus.req_mask;
                    order_d     = bus.fill_hi;
                    grant_acc_d = '0;
                    state_d     = (bus.req_mask != '0) ? S_ALLOC : S_DONE;
                end
            end
            S_ALLOC: begin
                if (alloc_valid_q) begin
                    busy_d      = busy_d | cap_onehot;
                    grant_acc_d = grant_acc_q | cap_onehot;
                    pending_d   = pending_q & ~ch_onehot;
                    if (pending_d == '0) begin
                        state_d = S_DONE;
                    end
                end else begin
                    overflow_d = 1'b1;
                    rem_mask_d = pending_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lowest pending channel of the next cycle.
    always_comb begin
        nxt_ch       = '0;
        nxt_ch_found = 1'b0;
        for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
            if (pending_d[i] && !nxt_ch_found) begin
                nxt_ch       = CH_W'(i);
                nxt_ch_found = 1'b1;
            end
        end
    end

    // Lowest and highest free slot of the next-cycle occupancy.
    always_comb begin
        lo_cap        = '0;
        hi_cap        = '0;
        nxt_cap_found = 1'b0;
        for (int unsigned i = 0; i < CAPACITOR_NUM; i++) begin
            if (!busy_d[i]) begin
                if (!nxt_cap_found) begin
                    lo_cap = CAP_W'(i);
                end
                hi_cap        = CAP_W'(i);
                nxt_cap_found = 1'b1;
            end
        end
        nxt_cap = order_d ? hi_cap : lo_cap;
    end

    // Output register inputs, including free-slot popcount.
    always_comb begin
        req_ready_d   = (state_d == S_IDLE);
        alloc_valid_d = (state_d == S_ALLOC) && nxt_ch_found && nxt_cap_found;
        alloc_ch_d    = alloc_valid_d ? nxt_ch : '0;
        alloc_cap_d   = alloc_valid_d ? nxt_cap : '0;
        grant_valid_d = (state_d == S_DONE);
        grant_mask_d  = (state_d == S_DONE) ? grant_acc_d : '0;
        free_cnt_d    = '0;
        for (int unsigned i = 0; i < CAPACITOR_NUM; i++) begin
            free_cnt_d = free_cnt_d + CNT_W'(~busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pending_q     <= '0;
            order_q       <= 1'b0;
            busy_q        <= '0;
            grant_acc_q   <= '0;
            free_cnt_q    <= CNT_W'(CAPACITOR_NUM);
            req_ready_q   <= 1'b1;
            alloc_valid_q <= 1'b0;
            alloc_ch_q    <= '0;
            alloc_cap_q   <= '0;
            grant_valid_q <= 1'b0;
            grant_mask_q  <= '0;
            overflow_q    <= 1'b0;
            rem_mask_q    <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            order_q       <= order_d;
            busy_q        <= busy_d;
            grant_acc_q   <= grant_acc_d;
            free_cnt_q    <= free_cnt_d;
            req_ready_q   <= req_ready_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_ch_q    <= alloc_ch_d;
            alloc_cap_q   <= alloc_cap_d;
            grant_valid_q <= grant_valid_d;
            grant_mask_q  <= grant_mask_d;
            overflow_q    <= overflow_d;
            rem_mask_q    <= rem_mask_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.alloc_valid = alloc_valid_q;
    assign bus.alloc_ch    = alloc_ch_q;
    assign bus.alloc_cap   = alloc_cap_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_mask  = grant_mask_q;
    assign bus.overflow    = overflow_q;
    assign bus.rem_mask    = rem_mask_q;
    assign bus.busy_mask   = busy_q;
    assign bus.free_cnt    = free_cnt_q;
endmodule

// File: tb/tb_route_distributor_seq.sv
// Self-checking bench for route_distributor_seq: directed scenarios plus randomized
// requests/releases against a slot-list reference model.
module tb_route_distributor_seq;
    localparam int unsigned CH  = 8;
    localparam int unsigned CAP = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    route_distributor_seq_if #(.CHANNEL_NUM(CH), .CAPACITOR_NUM(CAP)) bus ();

    route_distributor_seq #(.CHANNEL_NUM(CH), .CAPACITOR_NUM(CAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_slots();
        bus.release_mask = '1;
        tick();
        bus.release_mask = '0;
    endtask

    task automatic accept(input logic [7:0] m, input logic hi);
        bus.req_valid = 1'b1;
        bus.req_mask  = m;
        bus.fill_hi   = hi;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Runs a whole request from IDLE and returns in IDLE; only the completion bound is checked.
    task automatic do_request(input logic [7:0] m, input logic hi);
        int n;
        accept(m, hi);
        n = 0;
        while (bus.grant_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (bus.grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: grant_valid=%b required 1", bus.grant_valid);
        end
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.busy_mask !== 16'h0 || bus.free_cnt !== 5'd16) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%h free=%0d required 1/0000/16",
                     bus.req_ready, bus.busy_mask, bus.free_cnt);
        end
        checks++;
        if (bus.alloc_valid !== 1'b0 || bus.alloc_ch !== 3'd0 || bus.alloc_cap !== 4'd0 ||
            bus.grant_valid !== 1'b0 || bus.grant_mask !== 16'h0 || bus.overflow !== 1'b0 ||
            bus.rem_mask !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs: av=%b ch=%0d cap=%0d gv=%b gm=%h ovf=%b rem=%h required all 0",
                     bus.alloc_valid, bus.alloc_ch, bus.alloc_cap, bus.grant_valid,
                     bus.grant_mask, bus.overflow, bus.rem_mask);
        end
    endtask

    task automatic test_basic();
        accept(8'b0000_0101, 1'b0);
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_ch !== 3'd0 || bus.alloc_cap !== 4'd0) begin
            errors++;
            $display("FAIL basic_c1: av=%b ch=%0d cap=%0d required 1/0/0", bus.alloc_valid, bus.alloc_ch, bus.alloc_cap);
        end
        tick();
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_ch !== 3'd2 || bus.alloc_cap !== 4'd1) begin
            errors++;
            $display("FAIL basic_c2: av=%b ch=%0d cap=%0d required 1/2/1", bus.alloc_valid, bus.alloc_ch, bus.alloc_cap);
        end
        tick();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_mask !== 16'h0003 || bus.overflow !== 1'b0 ||
            bus.alloc_valid !== 1'b0 || bus.busy_mask !== 16'h0003 || bus.free_cnt !== 5'd14) begin
            errors++;
            $display("FAIL basic_grant: gv=%b gm=%h ovf=%b av=%b busy=%h free=%0d required 1/0003/0/0/0003/14",
                     bus.grant_valid, bus.grant_mask, bus.overflow, bus.alloc_valid, bus.busy_mask, bus.free_cnt);
        end
        tick();
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.grant_mask !== 16'h0) begin
            errors++;
            $display("FAIL basic_idle: gv=%b ready=%b gm=%h required 0/1/0000", bus.grant_valid, bus.req_ready, bus.grant_mask);
        end
        clear_slots();
    endtask

    task automatic test_fill_hi();
        accept(8'h01, 1'b1);
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_ch !== 3'd0 || bus.alloc_cap !== 4'd15) begin
            errors++;
            $display("FAIL fill_hi_alloc: av=%b ch=%0d cap=%0d required 1/0/15", bus.alloc_valid, bus.alloc_ch, bus.alloc_cap);
        end
        tick();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_mask !== 16'h8000 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_hi_grant: gv=%b gm=%h ovf=%b required 1/8000/0", bus.grant_valid, bus.grant_mask, bus.overflow);
        end
        tick();
        clear_slots();
    endtask

    task automatic test_overflow();
        do_request(8'hFF, 1'b0);
        do_request(8'h3F, 1'b0);
        checks++;
        if (bus.busy_mask !== 16'h3FFF || bus.free_cnt !== 5'd2) begin
            errors++;
            $display("FAIL ovf_prefill: busy=%h free=%0d required 3fff/2", bus.busy_mask, bus.free_cnt);
        end
        accept(8'h0F, 1'b0);
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_ch !== 3'd0 || bus.alloc_cap !== 4'd14) begin
            errors++;
            $display("FAIL ovf_c1: av=%b ch=%0d cap=%0d required 1/0/14", bus.alloc_valid, bus.alloc_ch, bus.alloc_cap);
        end
        tick();
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_ch !== 3'd1 || bus.alloc_cap !== 4'd15) begin
            errors++;
            $display("FAIL ovf_c2: av=%b ch=%0d cap=%0d required 1/1/15", bus.alloc_valid, bus.alloc_ch, bus.alloc_cap);
        end
        tick();
        checks++;
        if (bus.alloc_valid !== 1'b0 || bus.alloc_ch !== 3'd0 || bus.alloc_cap !== 4'd0 || bus.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_c3: av=%b ch=%0d cap=%0d gv=%b required 0/0/0/0", bus.alloc_valid, bus.alloc_ch, bus.alloc_cap, bus.grant_valid);
        end
        tick();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.overflow !== 1'b1 || bus.rem_mask !== 8'h0C ||
            bus.grant_mask !== 16'hC000 || bus.free_cnt !== 5'd0) begin
            errors++;
            $display("FAIL ovf_grant: gv=%b ovf=%b rem=%h gm=%h free=%0d required 1/1/0c/c000/0",
                     bus.grant_valid, bus.overflow, bus.rem_mask, bus.grant_mask, bus.free_cnt);
        end
        tick();
        checks++;
        if (bus.overflow !== 1'b0 || bus.rem_mask !== 8'h0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b rem=%h required 0/00", bus.overflow, bus.rem_mask);
        end
        clear_slots();
    endtask

    task automatic test_release_during_alloc();
        do_request(8'hFF, 1'b1);
        do_request(8'h7F, 1'b1);
        checks++;
        if (bus.busy_mask !== 16'hFFFE) begin
            errors++;
            $display("FAIL rel_prefill: busy=%h required fffe", bus.busy_mask);
        end
        accept(8'h07, 1'b0);
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_ch !== 3'd0 || bus.alloc_cap !== 4'd0) begin
            errors++;
            $display("FAIL rel_c1: av=%b ch=%0d cap=%0d required 1/0/0", bus.alloc_valid, bus.alloc_ch, bus.alloc_cap);
        end
        bus.release_mask = 16'h0100;
        tick();
        bus.release_mask = '0;
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_ch !== 3'd1 || bus.alloc_cap !== 4'd8) begin
            errors++;
            $display("FAIL rel_c2: av=%b ch=%0d cap=%0d required 1/1/8", bus.alloc_valid, bus.alloc_ch, bus.alloc_cap);
        end
        tick();
        checks++;
        if (bus.alloc_valid !== 1'b0) begin
            errors++;
            $display("FAIL rel_c3: av=%b required 0", bus.alloc_valid);
        end
        tick();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.overflow !== 1'b1 || bus.rem_mask !== 8'h04 ||
            bus.grant_mask !== 16'h0101 || bus.busy_mask !== 16'hFFFF || bus.free_cnt !== 5'd0) begin
            errors++;
            $display("FAIL rel_grant: gv=%b ovf=%b rem=%h gm=%h busy=%h free=%0d required 1/1/04/0101/ffff/0",
                     bus.grant_valid, bus.overflow, bus.rem_mask, bus.grant_mask, bus.busy_mask, bus.free_cnt);
        end
        tick();
        clear_slots();
    endtask

    task automatic test_empty();
        accept(8'h00, 1'b0);
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_mask !== 16'h0 || bus.overflow !== 1'b0 || bus.alloc_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_grant: gv=%b gm=%h ovf=%b av=%b required 1/0000/0/0",
                     bus.grant_valid, bus.grant_mask, bus.overflow, bus.alloc_valid);
        end
        tick();
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_idle: gv=%b ready=%b required 0/1", bus.grant_valid, bus.req_ready);
        end
        do_request(8'h01, 1'b0);
        bus.release_mask = 16'h0004;
        tick();
        bus.release_mask = '0;
        checks++;
        if (bus.busy_mask !== 16'h0001 || bus.free_cnt !== 5'd15) begin
            errors++;
            $display("FAIL release_free_slot: busy=%h free=%0d required 0001/15", bus.busy_mask, bus.free_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        accept(8'h0F, 1'b0);
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_cap !== 4'd1) begin
            errors++;
            $display("FAIL rstmid_alloc: av=%b cap=%0d required 1/1", bus.alloc_valid, bus.alloc_cap);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy_mask !== 16'h0 || bus.req_ready !== 1'b1 || bus.free_cnt !== 5'd16 || bus.alloc_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: busy=%h ready=%b free=%0d av=%b required 0000/1/16/0",
                     bus.busy_mask, bus.req_ready, bus.free_cnt, bus.alloc_valid);
        end
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.grant_valid === 1'b1) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_grant: grant seen=%b required 0", seen);
        end
    endtask

    // Reference model: occupancy vector plus a queue of pending channel numbers.
    task automatic test_random();
        logic [15:0] mb;
        logic [15:0] rel;
        logic [15:0] gexp;
        logic [7:0]  m;
        logic [7:0]  rem;
        logic        hi;
        logic        ovf;
        int          slot;
        int          pend[$];
        clear_slots();
        mb = 16'h0;
        for (int r = 0; r < 80; r++) begin
            m  = 8'($urandom);
            if ($urandom_range(0, 5) == 0) m = 8'h00;
            hi = 1'($urandom);
            rel = 16'($urandom & $urandom & $urandom);
            bus.release_mask = rel;
            accept(m, hi);
            mb = mb & ~rel;
            pend.delete();
            for (int i = 0; i < 8; i++) if (m[i]) pend.push_back(i);
            gexp = 16'h0;
            ovf  = 1'b0;
            while (pend.size() > 0 && !ovf) begin
                slot = -1;
                for (int s = 0; s < 16; s++) if (!mb[s] && (slot < 0 || hi)) slot = s;
                rel = 16'($urandom & $urandom & $urandom);
                bus.release_mask = rel;
                checks++;
                if (slot < 0) begin
                    if (bus.alloc_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_noalloc r%0d: av=%b required 0", r, bus.alloc_valid);
                    end
                    ovf = 1'b1;
                    mb  = mb & ~rel;
                end else begin
                    if (bus.alloc_valid !== 1'b1 || bus.alloc_ch !== 3'(pend[0]) || bus.alloc_cap !== 4'(slot)) begin
                        errors++;
                        $display("FAIL rand_alloc r%0d: av=%b ch=%0d cap=%0d required 1/%0d/%0d",
                                 r, bus.alloc_valid, bus.alloc_ch, bus.alloc_cap, pend[0], slot);
                    end
                    mb   = (mb & ~rel) | (16'(1) << slot);
                    gexp = gexp | (16'(1) << slot);
                    void'(pend.pop_front());
                end
                tick();
            end
            rem = 8'h0;
            foreach (pend[i]) rem[pend[i]] = 1'b1;
            checks++;
            if (bus.grant_valid !== 1'b1 || bus.grant_mask !== gexp || bus.overflow !== ovf ||
                bus.rem_mask !== rem || bus.busy_mask !== mb || bus.free_cnt !== 5'($countones(~mb))) begin
                errors++;
                $display("FAIL rand_grant r%0d: gv=%b gm=%h ovf=%b rem=%h busy=%h free=%0d required 1/%h/%b/%h/%h/%0d",
                         r, bus.grant_valid, bus.grant_mask, bus.overflow, bus.rem_mask, bus.busy_mask,
                         bus.free_cnt, gexp, ovf, rem, mb, $countones(~mb));
            end
            rel = 16'($urandom & $urandom & $urandom);
            bus.release_mask = rel;
            tick();
            mb = mb & ~rel;
            bus.release_mask = '0;
            checks++;
            if (bus.req_ready !== 1'b1 || bus.grant_valid !== 1'b0 || bus.busy_mask !== mb) begin
                errors++;
                $display("FAIL rand_idle r%0d: ready=%b gv=%b busy=%h required 1/0/%h",
                         r, bus.req_ready, bus.grant_valid, bus.busy_mask, mb);
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_mask     = '0;
        bus.fill_hi      = 1'b0;
        bus.release_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_fill_hi();
        test_overflow();
        test_release_during_alloc();
        test_empty();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
